move_capture: RTL and testbench
===============================

# move_capture

Parametrised human-move capture stage for the N×N board game. Armed by the game controller, it snapshots the current board and waits for released buttons. It then debounces a single cell-button press, validates that the cell is empty, and returns the updated board with a one-cycle `done` strobe. It sits between the front-panel button synchroniser and the game controller, in the slot the fixed 3×3 user player occupied, and adds debounce, release-arming, reject reporting, cancel and a move index output.

## Interface
- `BOARD_N`, 3: board side; `CELLS = BOARD_N*BOARD_N` (derived localparam).
- `DEBOUNCE_CYCLES`, 4: consecutive identical samples required; legal range 1..255.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: arm request; sampled only in IDLE.
- `cancel` input 1: abort from any state to IDLE; no `done`, no `reject`.
- `player_is_x` input 1: mark to place; 1 places 2'b01, 0 places 2'b10; sampled with `start`.
- `board_in` input 2*CELLS: packed board, cell i at [2i+1:2i]; 00 empty, 01 X, 10 O; snapshotted on accepted `start`.
- `buttons` input CELLS: synchronised level buttons, bit i = cell i.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on committed move.
- `reject` output 1: one-cycle pulse on an occupied-cell press or a multi-hot press.
- `move_idx` output $clog2(CELLS): committed cell index; valid from the `done` cycle; holds until the next commit.
- `board_out` output 2*CELLS: snapshot with the committed mark; updated in the `done` cycle; holds until the next commit.

## Operation
- States: IDLE, WAIT_RELEASE, WAIT_PRESS, DEBOUNCE.
- IDLE:
  - On `start`, latch `board_in` and `player_is_x`, clear the counter, go to WAIT_RELEASE.
  - `start` outside IDLE is ignored.
- WAIT_RELEASE:
  - Needs `buttons==0` for DEBOUNCE_CYCLES consecutive samples, then go to WAIT_PRESS.
  - Any nonzero sample clears the counter.
  - A button held across `start` therefore never commits.
- WAIT_PRESS:
  - `buttons==0`: stay.
  - One-hot: latch the one-hot vector and its index, counter=1, go to DEBOUNCE.
  - Multi-hot: pulse `reject`, go to WAIT_RELEASE.
- DEBOUNCE:
  - Sample equal to the latched vector: counter+1.
  - Sample differs: go to WAIT_PRESS with no reject (bounce).
- Commit, when the counter reaches DEBOUNCE_CYCLES:
  - Empty snapshot cell: write the mark into `board_out`, set `move_idx`, pulse `done`, go to IDLE.
  - Occupied cell: pulse `reject`, go to WAIT_RELEASE; the snapshot is unchanged.
- DEBOUNCE_CYCLES=1: the first one-hot sample in WAIT_PRESS commits directly.
- `cancel` has priority over every transition including commit. It returns to IDLE, and `board_out`/`move_idx` keep their old values.
- The snapshot is never refreshed while busy; the controller must not change the board during a move.

## Timing
- Reset values: `busy`=0, `done`=0, `reject`=0, `move_idx`=0, `board_out`=all 0, state IDLE, counters 0.
- Reset is applied immediately, mid-move included; no pulse is emitted.
- `busy` rises the cycle after the accepted `start` edge.
- Minimum latency from `start` to `done`: 2*DEBOUNCE_CYCLES+1 cycles, with buttons already released.
- From the first one-hot sample, `done` is high in the cycle after the DEBOUNCE_CYCLES-th matching sample.
- `done` and `reject` are registered and never high together; each lasts exactly one cycle.
- `busy` falls in the same cycle `done` rises.
- `cancel` in the commit cycle wins: no `done`.
- Counter width is 8 bits; it saturates, no wrap.

## Structure
- Shared package `game_pkg` holds:
  - cell encoding constants `CELL_EMPTY`, `CELL_X`, `CELL_O`;
  - `cell_t` 2-bit typedef;
  - the state enum `move_state_t`.
- One sub-module, `onehot_to_index`, parametrised by width. It outputs `is_zero`, `is_onehot` and `index`, and is reused by the AI player.

## Test plan
- Reset: assert `rst_n`=0 mid-DEBOUNCE → all outputs 0 asynchronously; after release, state IDLE and `busy`=0.
- Basic move (BOARD_N=3, DEBOUNCE_CYCLES=4): empty board, `player_is_x`=1, `start`; hold `buttons`=9'h010 → single `done`, `move_idx`=4, `board_out`[9:8]=01, all other cells 0.
- Occupied cell: `board_in` cell0=10, press 9'h001 for 4 cycles → `reject` once, no `done`. Release 4 cycles, press 9'h002 → `done`, `move_idx`=1.
- Bounce: 9'h008 for 2 cycles, 0 for 1 cycle, then 9'h008 for 4 cycles → exactly one `done`, `move_idx`=3.
- Multi-hot and held-at-start:
  - 9'h011 → one `reject`.
  - 9'h020 held from before `start` → no `done` until released 4 cycles and pressed again.
- Cancel and scaling:
  - `cancel` in the cycle commit would occur → no `done`, `board_out` unchanged.
  - BOARD_N=4: press bit 15 → `move_idx`=15, `board_out`[31:30] set.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the board-game datapath: cell encoding, move-capture
// state enum and a saturating counter helper.
package game_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_X     = 2'b01;
    localparam cell_t CELL_O     = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        WAIT_PRESS   = 2'd2,
        DEBOUNCE     = 2'd3
    } move_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Classifies a bit vector as zero / one-hot / multi-hot and encodes the index
// of the set bit (index is only meaningful when is_onehot is high).
module onehot_to_index #(
    parameter  int WIDTH = 9,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_zero,
    output logic             is_onehot,
    output logic [IDX_W-1:0] index
);

    // Power-of-two test plus OR-reduction of the set bit positions.
    always_comb begin
        is_zero   = (vec == '0);
        is_onehot = !is_zero && ((vec & (vec - WIDTH'(1))) == '0);
        index     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            index = index | (vec[i] ? IDX_W'(i) : '0);
        end
    end

endmodule

// File: rtl/move_capture.sv
// Human-move capture: snapshots the board when armed, waits for released
// buttons, debounces one cell press and commits it if the cell is empty.
module move_capture
    import game_pkg::*;
#(
    parameter  int BOARD_N         = 3,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CELLS           = BOARD_N * BOARD_N,
    localparam int IDX_W           = $clog2(CELLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cancel,
    input  logic               player_is_x,
    input  logic [2*CELLS-1:0] board_in,
    input  logic [CELLS-1:0]   buttons,
    output logic               busy,
    output logic               done,
    output logic               reject,
    output logic [IDX_W-1:0]   move_idx,
    output logic [2*CELLS-1:0] board_out
);

    localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_CYCLES);

    function automatic cell_t cell_at(input logic [2*CELLS-1:0] b, input logic [IDX_W-1:0] idx);
        cell_t c;
        c = CELL_EMPTY;
        for (int i = 0; i < CELLS; i++) begin
            c = (idx == IDX_W'(i)) ? b[2*i +: 2] : c;
        end
        return c;
    endfunction

    function automatic logic [2*CELLS-1:0] set_cell(input logic [2*CELLS-1:0] b,
                                                    input logic [IDX_W-1:0] idx,
                                                    input cell_t mark);
        logic [2*CELLS-1:0] r;
        r = b;
        for (int i = 0; i < CELLS; i++) begin
            r[2*i +: 2] = (idx == IDX_W'(i)) ? mark : b[2*i +: 2];
        end
        return r;
    endfunction

    move_state_t         state_r, state_n;
    logic [CNT_W-1:0]    cnt_r, cnt_n, cnt_inc_s;
    logic                busy_r, done_r, reject_r;
    logic                done_n, reject_n;
    logic [2*CELLS-1:0]  snap_r, board_out_r;
    cell_t               mark_r;
    logic [CELLS-1:0]    press_vec_r;
    logic [IDX_W-1:0]    press_idx_r, move_idx_r, commit_idx_s;
    logic                dec_zero_s, dec_onehot_s;
    logic [IDX_W-1:0]    dec_idx_s;
    logic                reached_s, target_free_s;
    logic                arm_s, latch_press_s, commit_s;

    onehot_to_index #(.WIDTH(CELLS)) u_dec (
        .vec       (buttons),
        .is_zero   (dec_zero_s),
        .is_onehot (dec_onehot_s),
        .index     (dec_idx_s)
    );

    assign cnt_inc_s     = sat_inc(cnt_r);
    assign reached_s     = (cnt_inc_s >= DB);
    // In DEBOUNCE the sample equals the latched vector, so the latched index is used.
    assign commit_idx_s  = (state_r == DEBOUNCE) ? press_idx_r : dec_idx_s;
    assign target_free_s = (cell_at(snap_r, commit_idx_s) == CELL_EMPTY);

    // Next-state, counter and pulse decode; cancel overrides everything.
    always_comb begin
        state_n       = state_r;
        cnt_n         = cnt_r;
        done_n        = 1'b0;
        reject_n      = 1'b0;
        arm_s         = 1'b0;
        latch_press_s = 1'b0;
        commit_s      = 1'b0;
        if (cancel) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        arm_s   = 1'b1;
                        state_n = WAIT_RELEASE;
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!dec_zero_s) begin
                        cnt_n = '0;
                    end else if (reached_s) begin
                        state_n = WAIT_PRESS;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc_s;
                    end
                end
                WAIT_PRESS: begin
                    if (dec_onehot_s && reached_s && target_free_s) begin
                        commit_s = 1'b1;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                        cnt_n    = '0;
                    end else if (dec_onehot_s && reached_s) begin
                        reject_n = 1'b1;
                        state_n  = WAIT_RELEASE;
                        cnt_n    = '0;
                    end else if (dec_onehot_s) begin
                        latch_press_s = 1'b1;
                        state_n       = DEBOUNCE;
                        cnt_n         = cnt_inc_s;
                    end else if (!dec_zero_s) begin
                        reject_n = 1'b1;
                        state_n  = WAIT_RELEASE;
                        cnt_n    = '0;
                    end else begin
                        state_n = WAIT_PRESS;
                    end
                end
                DEBOUNCE: begin
                    if (buttons != press_vec_r) begin
                        state_n = WAIT_PRESS;
                        cnt_n   = '0;
                    end else if (reached_s && target_free_s) begin
                        commit_s = 1'b1;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                        cnt_n    = '0;
                    end else if (reached_s) begin
                        reject_n = 1'b1;
                        state_n  = WAIT_RELEASE;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc_s;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Control state and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            reject_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            busy_r   <= (state_n != IDLE);
            done_r   <= done_n;
            reject_r <= reject_n;
        end
    end

    // Snapshot, press latch and committed result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_r      <= '0;
            mark_r      <= CELL_EMPTY;
            press_vec_r <= '0;
            press_idx_r <= '0;
            move_idx_r  <= '0;
            board_out_r <= '0;
        end else begin
            if (arm_s) begin
                snap_r <= board_in;
                mark_r <= player_is_x ? CELL_X : CELL_O;
            end
            if (latch_press_s) begin
                press_vec_r <= buttons;
                press_idx_r <= dec_idx_s;
            end
            if (commit_s) begin
                move_idx_r  <= commit_idx_s;
                board_out_r <= set_cell(snap_r, commit_idx_s, mark_r);
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign reject    = reject_r;
    assign move_idx  = move_idx_r;
    assign board_out = board_out_r;

endmodule

// File: tb/tb_move_capture.sv
// Bench for move_capture: directed scenarios plus random button traffic on a
// 3x3/4-cycle instance checked against a run-length model, and a 4x4/1-cycle instance.
module tb_move_capture;

    localparam int D3 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start3 = 1'b0, cancel3 = 1'b0, px3 = 1'b0;
    logic [17:0] bin3 = '0;
    logic [8:0]  btn3 = '0;
    logic        busy3, done3, reject3;
    logic [3:0]  idx3;
    logic [17:0] bout3;

    logic        start4 = 1'b0, cancel4 = 1'b0, px4 = 1'b0;
    logic [31:0] bin4 = '0;
    logic [15:0] btn4 = '0;
    logic        busy4, done4, reject4;
    logic [3:0]  idx4;
    logic [31:0] bout4;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int n_rej = 0;

    // reference model state
    bit          m_active = 1'b0, m_released = 1'b0, m_done = 1'b0, m_rej = 1'b0;
    int          m_run = 0;
    logic [8:0]  m_prev = '0;
    logic [17:0] m_snap = '0, m_bout = '0;
    logic [1:0]  m_mark = '0;
    logic [3:0]  m_idx = '0;

    move_capture #(.BOARD_N(3), .DEBOUNCE_CYCLES(D3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cancel(cancel3), .player_is_x(px3),
        .board_in(bin3), .buttons(btn3), .busy(busy3), .done(done3), .reject(reject3),
        .move_idx(idx3), .board_out(bout3)
    );

    move_capture #(.BOARD_N(4), .DEBOUNCE_CYCLES(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .cancel(cancel4), .player_is_x(px4),
        .board_in(bin4), .buttons(btn4), .busy(busy4), .done(done4), .reject(reject4),
        .move_idx(idx4), .board_out(bout4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_released = 1'b0; m_done = 1'b0; m_rej = 1'b0;
        m_run = 0; m_idx = '0; m_bout = '0;
    endtask

    // Model: arm, count a run of D3 zero samples, then count a run of D3 identical one-hot samples.
    task automatic model_step();
        int c;
        m_done = 1'b0;
        m_rej  = 1'b0;
        if (cancel3) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start3) begin
                m_active = 1'b1; m_released = 1'b0; m_run = 0;
                m_snap = bin3; m_mark = px3 ? 2'b01 : 2'b10;
            end
        end else if (!m_released) begin
            if (btn3 == 9'd0) begin
                m_run++;
                if (m_run >= D3) begin m_released = 1'b1; m_run = 0; end
            end else begin
                m_run = 0;
            end
        end else if (m_run > 0 && btn3 != m_prev) begin
            m_run = 0;
        end else if ($countones(btn3) > 1) begin
            m_rej = 1'b1; m_released = 1'b0; m_run = 0;
        end else if ($countones(btn3) == 1) begin
            m_prev = btn3;
            m_run++;
            if (m_run >= D3) begin
                c = 0;
                for (int i = 0; i < 9; i++) if (btn3[i]) c = i;
                if (m_snap[2*c +: 2] == 2'b00) begin
                    m_bout = m_snap;
                    m_bout[2*c +: 2] = m_mark;
                    m_idx = 4'(c);
                    m_done = 1'b1;
                    m_active = 1'b0;
                end else begin
                    m_rej = 1'b1; m_released = 1'b0; m_run = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("busy", 32'(busy3), 32'(m_active));
        chk("done", 32'(done3), 32'(m_done));
        chk("reject", 32'(reject3), 32'(m_rej));
        chk("move_idx", 32'(idx3), 32'(m_idx));
        chk("board_out", 32'(bout3), 32'(m_bout));
        if (done3) n_done++;
        if (reject3) n_rej++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm(input logic [17:0] b, input logic x);
        bin3 = b; px3 = x; start3 = 1'b1;
        tick();
        start3 = 1'b0;
    endtask

    function automatic logic [17:0] rand_board();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'($urandom_range(0, 2));
        return b;
    endfunction

    initial begin
        int d0, r0, k, len, got, lat;
        #12;
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_done", 32'(done3), 32'd0);
        chk("rst_board", 32'(bout3), 32'd0);
        chk("rst4_board", bout4, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic move
        d0 = n_done;
        arm(18'h0, 1'b1);
        ticks(D3);
        btn3 = 9'h010; ticks(5);
        btn3 = 9'h000; ticks(2);
        chk("basic_count", 32'(n_done - d0), 32'd1);
        chk("basic_idx", 32'(idx3), 32'd4);
        chk("basic_board", 32'(bout3), 32'h100);

        // occupied cell then valid press
        d0 = n_done; r0 = n_rej;
        arm(18'h00002, 1'b1);
        ticks(D3);
        btn3 = 9'h001; ticks(4);
        btn3 = 9'h000; ticks(4);
        btn3 = 9'h002; ticks(5);
        btn3 = 9'h000; ticks(1);
        chk("occ_rej", 32'(n_rej - r0), 32'd1);
        chk("occ_done", 32'(n_done - d0), 32'd1);
        chk("occ_idx", 32'(idx3), 32'd1);
        chk("occ_board", 32'(bout3), 32'h6);

        // bounce
        d0 = n_done;
        arm(18'h0, 1'b0);
        ticks(D3);
        btn3 = 9'h008; ticks(2);
        btn3 = 9'h000; ticks(1);
        btn3 = 9'h008; ticks(5);
        btn3 = 9'h000; ticks(1);
        chk("bounce_done", 32'(n_done - d0), 32'd1);
        chk("bounce_idx", 32'(idx3), 32'd3);
        chk("bounce_board", 32'(bout3), 32'h80);

        // multi-hot
        r0 = n_rej;
        arm(18'h0, 1'b1);
        ticks(D3);
        btn3 = 9'h011; ticks(1);
        btn3 = 9'h000; ticks(1);
        chk("multi_rej", 32'(n_rej - r0), 32'd1);
        cancel3 = 1'b1; ticks(1); cancel3 = 1'b0;

        // held across start
        d0 = n_done;
        btn3 = 9'h020;
        arm(18'h0, 1'b1);
        ticks(8);
        chk("held_nodone", 32'(n_done - d0), 32'd0);
        chk("held_busy", 32'(busy3), 32'd1);
        btn3 = 9'h000; ticks(D3);
        btn3 = 9'h020; ticks(5);
        btn3 = 9'h000; ticks(1);
        chk("held_done", 32'(n_done - d0), 32'd1);
        chk("held_idx", 32'(idx3), 32'd5);

        // cancel in the commit cycle
        d0 = n_done;
        arm(18'h0, 1'b0);
        ticks(D3);
        btn3 = 9'h080; ticks(3);
        cancel3 = 1'b1; ticks(1);
        cancel3 = 1'b0; btn3 = 9'h000; ticks(1);
        chk("cancel_nodone", 32'(n_done - d0), 32'd0);
        chk("cancel_board", 32'(bout3), 32'h400);
        chk("cancel_busy", 32'(busy3), 32'd0);

        // asynchronous reset mid-DEBOUNCE
        arm(18'h0, 1'b1);
        ticks(D3);
        btn3 = 9'h040; ticks(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy3), 32'd0);
        chk("arst_idx", 32'(idx3), 32'd0);
        chk("arst_board", 32'(bout3), 32'd0);
        chk("arst_done", 32'(done3), 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        btn3 = 9'h000;
        ticks(2);

        // random traffic
        for (int s = 0; s < 150; s++) begin
            k = $urandom_range(0, 99);
            start3  = (k < 30);
            cancel3 = (k >= 97);
            if (k < 30) begin
                bin3 = rand_board();
                px3  = 1'($urandom_range(0, 1));
            end
            k = $urandom_range(0, 9);
            if (k < 4)       btn3 = 9'h000;
            else if (k < 8)  btn3 = 9'(1 << $urandom_range(0, 8));
            else if (k == 8) btn3 = 9'h101;
            else             btn3 = 9'($urandom);
            len = $urandom_range(1, 6);
            for (int t = 0; t < len; t++) begin
                tick();
                start3 = 1'b0; cancel3 = 1'b0;
            end
        end
        start3 = 1'b0; cancel3 = 1'b0; btn3 = 9'h000;
        ticks(2);

        // 4x4 board, single-sample debounce
        start4 = 1'b1; bin4 = 32'h0; px4 = 1'b0;
        tick();
        start4 = 1'b0;
        chk("d4_busy", 32'(busy4), 32'd1);
        tick();
        btn4 = 16'h8000;
        got = 0; lat = -1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 && got == 0) begin got = 1; lat = i; end
        end
        btn4 = 16'h0;
        chk("d4_done_seen", 32'(got), 32'd1);
        chk("d4_latency", 32'(lat), 32'd0);
        chk("d4_idx", 32'(idx4), 32'd15);
        chk("d4_board", bout4, 32'h8000_0000);
        chk("d4_reject", 32'(reject4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
